friscv_cache_refill: RTL and testbench
======================================

// Module: friscv_cache_refill
// PURPOSE
//  Miss-handling stage directly upstream of the cache memory controller.
//  - Accepts cache-miss requests from the fetcher and issues AXI4-lite reads to the controller.
//  - On completion, writes the returned block into the cache (cacheable requests only).
//  - Forwards the XLEN word to the requester.
//  - Tracks in-flight lines so a line is never fetched twice, and runs the flush/erase sweep.
// PARAMETERS
//  XLEN          32     instruction/data word width
//  AXI_ADDR_W    10     address width
//  AXI_ID_W      8      AXI ID width
//  AXI_ID_MASK   'h20   OR-ed into every issued ARID
//  OSTDREQ_NUM   4      max outstanding reads, power of 2
//  CACHE_BLOCK_W 128    line payload width, bits
//  CACHE_LINES   64     number of lines swept on flush, power of 2
// PORTS
//  aclk          in  1               clock
//  arst          in  1               asynchronous active-high reset
//  flush_req     in  1               level; request cache erase
//  flush_ack     out 1               1-cycle pulse when erase completes
//  miss_valid    in  1               miss request valid
//  miss_ready    out 1               miss request accepted
//  miss_addr     in  AXI_ADDR_W      byte address of the miss
//  miss_io       in  1               1 = IO/non-cacheable, bypass cache fill
//  mst_arvalid   out 1               read request to memctrl
//  mst_arready   in  1
//  mst_araddr    out AXI_ADDR_W      = miss_addr, unaligned
//  mst_arprot    out 3               fixed 3'b000
//  mst_arcache   out 4               miss_io ? 4'b0000 : 4'b0010
//  mst_arid      out AXI_ID_W        AXI_ID_MASK | wr_ptr
//  mst_rvalid    in  1               completion from memctrl
//  mst_rready    out 1
//  mst_rcache    in  1               1 = fill cache
//  mst_raddr     in  AXI_ADDR_W      original request address
//  mst_rresp     in  2
//  mst_rdata_blk in  CACHE_BLOCK_W   full line
//  mst_rdata     in  XLEN            extracted word
//  cache_wen     out 1               cache line write strobe
//  cache_waddr   out AXI_ADDR_W      line-aligned write address
//  cache_wdata   out CACHE_BLOCK_W   line payload
//  cache_wvld    out 1               line valid bit written
//  cpl_valid     out 1               completion to requester
//  cpl_ready     in  1
//  cpl_addr      out AXI_ADDR_W
//  cpl_data      out XLEN
//  cpl_err       out 1               mst_rresp != OKAY
// BEHAVIOUR
//  Reset: all outputs 0, FSM=RUN, table empty, pointers 0; reset mid-transfer drops all state.
//  Pending table: circular, OSTDREQ_NUM entries {vld, line}, where line = addr[AXI_ADDR_W-1:LINE_LSB]
//    and LINE_LSB = log2(CACHE_BLOCK_W/8); wr_ptr/rd_ptr are NB_TAG_W bits + wrap bit.
//  RUN state:
//   - ar channel is combinational pass-through: mst_arvalid = miss_valid & !full & !hit & state==RUN.
//   - miss_ready = mst_arready & !full & !hit & state==RUN.
//   - hit: any vld entry whose line equals the miss line and miss_io=0 -> stall, no duplicate fetch.
//     IO misses never stall on hit.
//   - On miss_valid & miss_ready: push entry at wr_ptr, wr_ptr++.
//  Completion (in-order): mst_rready = !cpl_valid | cpl_ready.
//   On mst_rvalid & mst_rready:
//   - pop rd_ptr;
//   - same cycle: cache_wen = mst_rcache & (rresp==OKAY), cache_waddr = line-aligned mst_raddr,
//     cache_wdata = mst_rdata_blk, cache_wvld = 1;
//   - register cpl_* (1-cycle latency), held until cpl_ready.
//   Simultaneous push and pop allowed; a hit on the entry being popped still stalls that cycle.
//  FSM RUN -> DRAIN on flush_req: stop accepting misses.
//  DRAIN -> ERASE when table empty and no cpl pending.
//  ERASE: counter 0..CACHE_LINES-1, one write per cycle:
//   cache_wen=1, cache_wvld=0, cache_waddr=idx<<LINE_LSB, cache_wdata=0.
//  ERASE -> RUN after the last index; flush_ack pulses 1 cycle then.
//  flush_req held across flush_ack does not retrigger until it drops for >=1 cycle.
//  Unexpected mst_rvalid on an empty table: accept, no cache write; FRISCV_SIM $display error.
// STRUCTURE
//  friscv_h.sv: add RRESP codes (OKAY=2'b00) and the ARCACHE encodings above as localparams.
//  Sub-module friscv_cache_pending_tbl: table + compare + pointers; ports push/pop/line/hit/full/empty.
//  Top level: FSM, erase counter, completion register.
// TESTING
//  1) Miss 0x040, arready=1, rvalid 3 cycles later, rcache=1
//     -> one ar with arid=0x20; cache_wen with waddr=0x040; cpl_data = rdata one cycle later.
//  2) Misses 0x040 then 0x044, line not returned
//     -> second stalls (miss_ready=0) until first completes; then re-issued, ar count = 2.
//  3) Four misses to distinct lines, no completions
//     -> full, 5th stalls; completions in order free entries; arid 0x20..0x23 then wraps to 0x20.
//  4) IO miss (miss_io=1) -> arcache=0; rcache=0 -> no cache_wen; cpl valid.
//     rresp=2'b10 -> cpl_err=1, no cache write.
//  5) flush_req with 2 outstanding -> misses blocked; after drain, 64 erase writes (waddr 0,0x10,..,0x3F0);
//     flush_ack 1 cycle.
//  6) arst asserted mid-erase and with cpl pending -> all outputs 0 next edge, table empty, RUN.

Source files
------------

// File: rtl/friscv_cache_refill_pkg.sv
// Shared AXI encodings and FSM states for the cache miss refill stage.
package friscv_cache_refill_pkg;

  localparam logic [1:0] RRESP_OKAY  = 2'b00;
  localparam logic [3:0] ARCACHE_IO  = 4'b0000;
  localparam logic [3:0] ARCACHE_MEM = 4'b0010;
  localparam logic [2:0] ARPROT_DEF  = 3'b000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ERASE = 2'd2
  } state_t;

endpackage

// File: rtl/friscv_cache_pending_tbl.sv
// Circular table of in-flight line fetches: in-order push/pop plus a
// parallel compare of the incoming miss line against every valid entry.
module friscv_cache_pending_tbl #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 6,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [LINE_W-1:0] line_i,
  output logic              hit_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [TAG_W-1:0]  wr_tag_o
);

  logic [TAG_W:0]    wr_ptr_q, wr_ptr_d;
  logic [TAG_W:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [LINE_W-1:0] line_q [DEPTH];
  logic [LINE_W-1:0] line_d [DEPTH];
  logic [DEPTH-1:0]  match;
  logic              push_ok;
  logic              pop_ok;

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[TAG_W-1:0] == rd_ptr_q[TAG_W-1:0]) &&
                    (wr_ptr_q[TAG_W] != rd_ptr_q[TAG_W]);
  assign push_ok  = push_i & ~full_o;
  assign pop_ok   = pop_i & ~empty_o;
  assign wr_tag_o = wr_ptr_q[TAG_W-1:0];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = vld_q[gi] && (line_q[gi] == line_i);
    end
  endgenerate

  assign hit_o = |match;

  always_comb begin
    vld_d    = vld_q;
    line_d   = line_q;
    wr_ptr_d = wr_ptr_q + {{TAG_W{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{TAG_W{1'b0}}, pop_ok};
    if (pop_ok) begin
      vld_d[rd_ptr_q[TAG_W-1:0]] = 1'b0;
    end
    if (push_ok) begin
      vld_d[wr_ptr_q[TAG_W-1:0]]  = 1'b1;
      line_d[wr_ptr_q[TAG_W-1:0]] = line_i;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      line_q   <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      line_q   <= line_d;
    end
  end

endmodule

// File: rtl/friscv_cache_refill.sv
// Cache miss refill stage: issues line reads, fills the cache on return,
// forwards the word to the requester and sweeps the cache on flush.
module friscv_cache_refill
  import friscv_cache_refill_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int AXI_ADDR_W    = 10,
  parameter int AXI_ID_W      = 8,
  parameter int AXI_ID_MASK   = 'h20,
  parameter int OSTDREQ_NUM   = 4,
  parameter int CACHE_BLOCK_W = 128,
  parameter int CACHE_LINES   = 64
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic                     flush_req,
  output logic                     flush_ack,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic [AXI_ADDR_W-1:0]    miss_addr,
  input  logic                     miss_io,
  output logic                     mst_arvalid,
  input  logic                     mst_arready,
  output logic [AXI_ADDR_W-1:0]    mst_araddr,
  output logic [2:0]               mst_arprot,
  output logic [3:0]               mst_arcache,
  output logic [AXI_ID_W-1:0]      mst_arid,
  input  logic                     mst_rvalid,
  output logic                     mst_rready,
  input  logic                     mst_rcache,
  input  logic [AXI_ADDR_W-1:0]    mst_raddr,
  input  logic [1:0]               mst_rresp,
  input  logic [CACHE_BLOCK_W-1:0] mst_rdata_blk,
  input  logic [XLEN-1:0]          mst_rdata,
  output logic                     cache_wen,
  output logic [AXI_ADDR_W-1:0]    cache_waddr,
  output logic [CACHE_BLOCK_W-1:0] cache_wdata,
  output logic                     cache_wvld,
  output logic                     cpl_valid,
  input  logic                     cpl_ready,
  output logic [AXI_ADDR_W-1:0]    cpl_addr,
  output logic [XLEN-1:0]          cpl_data,
  output logic                     cpl_err
);

  localparam int LINE_LSB = $clog2(CACHE_BLOCK_W / 8);
  localparam int LINE_W   = AXI_ADDR_W - LINE_LSB;
  localparam int TAG_W    = $clog2(OSTDREQ_NUM);
  localparam int ERASE_W  = $clog2(CACHE_LINES);
  localparam logic [AXI_ID_W-1:0] ID_MASK    = AXI_ID_W'(AXI_ID_MASK);
  localparam logic [ERASE_W-1:0]  ERASE_LAST = ERASE_W'(CACHE_LINES - 1);

  state_t                state_q, state_d;
  logic [ERASE_W-1:0]    erase_idx_q, erase_idx_d;
  logic                  flush_armed_q, flush_armed_d;
  logic                  flush_ack_q, flush_ack_d;
  logic                  cpl_valid_q, cpl_valid_d;
  logic [AXI_ADDR_W-1:0] cpl_addr_q, cpl_addr_d;
  logic [XLEN-1:0]       cpl_data_q, cpl_data_d;
  logic                  cpl_err_q, cpl_err_d;

  logic             tbl_hit;
  logic             tbl_full;
  logic             tbl_empty;
  logic [TAG_W-1:0] wr_tag;
  logic             run;
  logic             hit_stall;
  logic             push;
  logic             pop;
  logic             fill_wen;

  friscv_cache_pending_tbl #(
    .DEPTH  (OSTDREQ_NUM),
    .LINE_W (LINE_W),
    .TAG_W  (TAG_W)
  ) u_pending_tbl (
    .aclk     (aclk),
    .arst     (arst),
    .push_i   (push),
    .pop_i    (pop),
    .line_i   (miss_addr[AXI_ADDR_W-1:LINE_LSB]),
    .hit_o    (tbl_hit),
    .full_o   (tbl_full),
    .empty_o  (tbl_empty),
    .wr_tag_o (wr_tag)
  );

  // IO accesses are never cached, so they may overlap an in-flight line fetch.
  assign run         = (state_q == ST_RUN);
  assign hit_stall   = tbl_hit & ~miss_io;
  assign mst_arvalid = miss_valid & ~tbl_full & ~hit_stall & run;
  assign miss_ready  = mst_arready & ~tbl_full & ~hit_stall & run;
  assign push        = miss_valid & miss_ready;
  assign mst_araddr  = miss_addr;
  assign mst_arprot  = ARPROT_DEF;
  assign mst_arcache = miss_io ? ARCACHE_IO : ARCACHE_MEM;
  assign mst_arid    = ID_MASK | AXI_ID_W'(wr_tag);

  // A completion with nothing outstanding is consumed and dropped.
  assign mst_rready = ~cpl_valid_q | cpl_ready;
  assign pop        = mst_rvalid & mst_rready & ~tbl_empty;
  assign fill_wen   = pop & mst_rcache & (mst_rresp == RRESP_OKAY);

  assign flush_ack = flush_ack_q;
  assign cpl_valid = cpl_valid_q;
  assign cpl_addr  = cpl_addr_q;
  assign cpl_data  = cpl_data_q;
  assign cpl_err   = cpl_err_q;

  always_comb begin
    state_d       = state_q;
    erase_idx_d   = erase_idx_q;
    flush_ack_d   = 1'b0;
    flush_armed_d = flush_armed_q | ~flush_req;
    cache_wen     = fill_wen;
    cache_wvld    = fill_wen;
    cache_waddr   = fill_wen ? {mst_raddr[AXI_ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}} : '0;
    cache_wdata   = fill_wen ? mst_rdata_blk : '0;
    case (state_q)
      ST_RUN: begin
        // A flush held high across its ack must drop before it can fire again.
        if (flush_req && flush_armed_q) begin
          state_d       = ST_DRAIN;
          flush_armed_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        erase_idx_d = '0;
        if (tbl_empty && !cpl_valid_q) begin
          state_d = ST_ERASE;
        end
      end
      ST_ERASE: begin
        cache_wen   = 1'b1;
        cache_wvld  = 1'b0;
        cache_waddr = AXI_ADDR_W'({erase_idx_q, {LINE_LSB{1'b0}}});
        cache_wdata = '0;
        if (erase_idx_q == ERASE_LAST) begin
          state_d     = ST_RUN;
          erase_idx_d = '0;
          flush_ack_d = 1'b1;
        end else begin
          erase_idx_d = erase_idx_q + ERASE_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    cpl_valid_d = cpl_valid_q;
    cpl_addr_d  = cpl_addr_q;
    cpl_data_d  = cpl_data_q;
    cpl_err_d   = cpl_err_q;
    if (pop) begin
      cpl_valid_d = 1'b1;
      cpl_addr_d  = mst_raddr;
      cpl_data_d  = mst_rdata;
      cpl_err_d   = (mst_rresp != RRESP_OKAY);
    end else if (cpl_ready) begin
      cpl_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q       <= ST_RUN;
      erase_idx_q   <= '0;
      flush_armed_q <= 1'b1;
      flush_ack_q   <= 1'b0;
      cpl_valid_q   <= 1'b0;
      cpl_addr_q    <= '0;
      cpl_data_q    <= '0;
      cpl_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      erase_idx_q   <= erase_idx_d;
      flush_armed_q <= flush_armed_d;
      flush_ack_q   <= flush_ack_d;
      cpl_valid_q   <= cpl_valid_d;
      cpl_addr_q    <= cpl_addr_d;
      cpl_data_q    <= cpl_data_d;
      cpl_err_q     <= cpl_err_d;
    end
  end

endmodule

// File: tb/tb_friscv_cache_refill.sv
// Directed bench for friscv_cache_refill: misses, stalls, completions, flush and reset.
`timescale 1ns/1ps
module tb_friscv_cache_refill;

  logic         aclk = 1'b0;
  logic         arst = 1'b1;
  logic         flush_req = 1'b0;
  logic         flush_ack;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [9:0]   miss_addr = '0;
  logic         miss_io = 1'b0;
  logic         mst_arvalid;
  logic         mst_arready = 1'b0;
  logic [9:0]   mst_araddr;
  logic [2:0]   mst_arprot;
  logic [3:0]   mst_arcache;
  logic [7:0]   mst_arid;
  logic         mst_rvalid = 1'b0;
  logic         mst_rready;
  logic         mst_rcache = 1'b0;
  logic [9:0]   mst_raddr = '0;
  logic [1:0]   mst_rresp = '0;
  logic [127:0] mst_rdata_blk = '0;
  logic [31:0]  mst_rdata = '0;
  logic         cache_wen;
  logic [9:0]   cache_waddr;
  logic [127:0] cache_wdata;
  logic         cache_wvld;
  logic         cpl_valid;
  logic         cpl_ready = 1'b1;
  logic [9:0]   cpl_addr;
  logic [31:0]  cpl_data;
  logic         cpl_err;

  int n_checks  = 0;
  int n_fail    = 0;
  int ar_cnt    = 0;
  int erase_cnt = 0;
  int ack_cnt   = 0;
  int ar_base;

  friscv_cache_refill dut (
    .aclk(aclk), .arst(arst), .flush_req(flush_req), .flush_ack(flush_ack),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_io(miss_io),
    .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_araddr(mst_araddr),
    .mst_arprot(mst_arprot), .mst_arcache(mst_arcache), .mst_arid(mst_arid),
    .mst_rvalid(mst_rvalid), .mst_rready(mst_rready), .mst_rcache(mst_rcache),
    .mst_raddr(mst_raddr), .mst_rresp(mst_rresp), .mst_rdata_blk(mst_rdata_blk),
    .mst_rdata(mst_rdata), .cache_wen(cache_wen), .cache_waddr(cache_waddr),
    .cache_wdata(cache_wdata), .cache_wvld(cache_wvld), .cpl_valid(cpl_valid),
    .cpl_ready(cpl_ready), .cpl_addr(cpl_addr), .cpl_data(cpl_data), .cpl_err(cpl_err)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Handshake and erase-sweep monitors, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!arst && mst_arvalid && mst_arready) ar_cnt++;
    if (flush_ack) ack_cnt++;
    if (cache_wen && !cache_wvld) begin
      check_eq("erase_waddr", 128'(cache_waddr), 128'(erase_cnt * 16));
      check_eq("erase_wdata", cache_wdata, 128'd0);
      erase_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic neg();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    arst = 1'b1; miss_valid = 1'b0; mst_rvalid = 1'b0; flush_req = 1'b0;
    cpl_ready = 1'b1; mst_arready = 1'b1; miss_io = 1'b0;
    tick(); tick();
    arst = 1'b0;
  endtask

  task automatic issue(input logic [9:0] a, input logic io, input logic [7:0] exp_id);
    miss_valid = 1'b1; miss_addr = a; miss_io = io;
    neg();
    check_eq("issue_ready", 128'(miss_ready), 128'd1);
    check_eq("issue_arid", 128'(mst_arid), 128'(exp_id));
    tick();
    miss_valid = 1'b0; miss_io = 1'b0;
  endtask

  task automatic rsp_start(input logic [9:0] a, input logic rc, input logic [1:0] rs,
                           input logic [31:0] d, input logic exp_wen);
    mst_rvalid = 1'b1; mst_rcache = rc; mst_raddr = a; mst_rresp = rs;
    mst_rdata = d; mst_rdata_blk = {4{d}};
    neg();
    check_eq("rsp_rready", 128'(mst_rready), 128'd1);
    check_eq("rsp_wen", 128'(cache_wen), 128'(exp_wen));
    if (exp_wen) begin
      check_eq("rsp_waddr", 128'(cache_waddr), 128'({a[9:4], 4'h0}));
      check_eq("rsp_wdata", cache_wdata, 128'({4{d}}));
      check_eq("rsp_wvld", 128'(cache_wvld), 128'd1);
    end
  endtask

  task automatic rsp_end(input logic [9:0] a, input logic [31:0] d, input logic exp_err);
    tick();
    mst_rvalid = 1'b0;
    neg();
    check_eq("cpl_valid", 128'(cpl_valid), 128'd1);
    check_eq("cpl_addr", 128'(cpl_addr), 128'(a));
    check_eq("cpl_data", 128'(cpl_data), 128'(d));
    check_eq("cpl_err", 128'(cpl_err), 128'(exp_err));
    $display("cpl addr=%03h data=%08h err=%0d", cpl_addr, cpl_data, cpl_err);
  endtask

  initial begin
    logic [9:0] t3_addr [5];
    t3_addr = '{10'h100, 10'h200, 10'h300, 10'h000, 10'h080};

    // Reset state
    neg();
    check_eq("rst_cpl_valid", 128'(cpl_valid), 128'd0);
    check_eq("rst_cache_wen", 128'(cache_wen), 128'd0);
    check_eq("rst_flush_ack", 128'(flush_ack), 128'd0);
    check_eq("rst_arvalid", 128'(mst_arvalid), 128'd0);
    check_eq("rst_miss_ready", 128'(miss_ready), 128'd0);
    do_reset();

    // 1) single cacheable miss, response three cycles after the request
    miss_valid = 1'b1; miss_addr = 10'h040;
    neg();
    check_eq("t1_arvalid", 128'(mst_arvalid), 128'd1);
    check_eq("t1_arid", 128'(mst_arid), 128'h20);
    check_eq("t1_araddr", 128'(mst_araddr), 128'h040);
    check_eq("t1_arcache", 128'(mst_arcache), 128'h2);
    check_eq("t1_arprot", 128'(mst_arprot), 128'h0);
    tick();
    miss_valid = 1'b0;
    tick(); tick();
    rsp_start(10'h040, 1'b1, 2'b00, 32'hDEADBEEF, 1'b1);
    rsp_end(10'h040, 32'hDEADBEEF, 1'b0);
    check_eq("t1_wen_after", 128'(cache_wen), 128'd0);
    tick();
    neg();
    check_eq("t1_cpl_clear", 128'(cpl_valid), 128'd0);
    tick();

    // 2) second miss to an in-flight line stalls until the line returns
    ar_base = ar_cnt;
    issue(10'h040, 1'b0, 8'h21);
    miss_valid = 1'b1; miss_addr = 10'h044;
    neg();
    check_eq("t2_stall_ready", 128'(miss_ready), 128'd0);
    check_eq("t2_stall_arvalid", 128'(mst_arvalid), 128'd0);
    tick();
    neg();
    check_eq("t2_stall2_ready", 128'(miss_ready), 128'd0);
    tick();
    rsp_start(10'h040, 1'b1, 2'b00, 32'h11112222, 1'b1);
    check_eq("t2_stall_on_pop", 128'(miss_ready), 128'd0);
    rsp_end(10'h040, 32'h11112222, 1'b0);
    check_eq("t2_reissue_ready", 128'(miss_ready), 128'd1);
    check_eq("t2_reissue_arid", 128'(mst_arid), 128'h22);
    tick();
    miss_valid = 1'b0;
    neg();
    check_eq("t2_ar_count", 128'(ar_cnt - ar_base), 128'd2);
    tick();
    rsp_start(10'h044, 1'b1, 2'b00, 32'h33334444, 1'b1);
    rsp_end(10'h044, 32'h33334444, 1'b0);
    tick();

    // 3) fill the table, fifth miss stalls, ARID wraps after the first completion
    do_reset();
    for (int k = 0; k < 4; k++) issue(t3_addr[k], 1'b0, 8'h20 + 8'(k));
    miss_valid = 1'b1; miss_addr = t3_addr[4];
    neg();
    check_eq("t3_full_ready", 128'(miss_ready), 128'd0);
    check_eq("t3_full_arvalid", 128'(mst_arvalid), 128'd0);
    tick();
    rsp_start(t3_addr[0], 1'b1, 2'b00, 32'hA0A0A0A0, 1'b1);
    check_eq("t3_full_on_pop", 128'(miss_ready), 128'd0);
    rsp_end(t3_addr[0], 32'hA0A0A0A0, 1'b0);
    check_eq("t3_freed_ready", 128'(miss_ready), 128'd1);
    check_eq("t3_wrap_arid", 128'(mst_arid), 128'h20);
    tick();
    miss_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      rsp_start(t3_addr[k], 1'b1, 2'b00, 32'hB0000000 + 32'(k), 1'b1);
      rsp_end(t3_addr[k], 32'hB0000000 + 32'(k), 1'b0);
      tick();
    end

    // 4) IO misses: no hit stall, no cache fill, error response flagged
    issue(10'h040, 1'b0, 8'h21);
    miss_valid = 1'b1; miss_addr = 10'h048; miss_io = 1'b1;
    neg();
    check_eq("t4_io_no_stall", 128'(miss_ready), 128'd1);
    check_eq("t4_io_arcache", 128'(mst_arcache), 128'h0);
    check_eq("t4_io_arid", 128'(mst_arid), 128'h22);
    tick();
    miss_valid = 1'b0; miss_io = 1'b0;
    rsp_start(10'h040, 1'b1, 2'b00, 32'hC0C0C0C0, 1'b1);
    rsp_end(10'h040, 32'hC0C0C0C0, 1'b0);
    tick();
    rsp_start(10'h048, 1'b0, 2'b00, 32'h12345678, 1'b0);
    rsp_end(10'h048, 32'h12345678, 1'b0);
    tick();
    issue(10'h050, 1'b1, 8'h23);
    rsp_start(10'h050, 1'b1, 2'b10, 32'hBADBAD00, 1'b0);
    rsp_end(10'h050, 32'hBADBAD00, 1'b1);
    tick();

    // 5) flush with two outstanding: drain, 64-line sweep, single ack, no retrigger
    erase_cnt = 0; ack_cnt = 0;
    issue(10'h100, 1'b0, 8'h20);
    issue(10'h200, 1'b0, 8'h21);
    flush_req = 1'b1;
    tick();
    miss_valid = 1'b1; miss_addr = 10'h300;
    neg();
    check_eq("t5_drain_ready", 128'(miss_ready), 128'd0);
    check_eq("t5_drain_arvalid", 128'(mst_arvalid), 128'd0);
    tick();
    miss_valid = 1'b0;
    rsp_start(10'h100, 1'b1, 2'b00, 32'h01000100, 1'b1);
    rsp_end(10'h100, 32'h01000100, 1'b0);
    tick();
    rsp_start(10'h200, 1'b1, 2'b00, 32'h02000200, 1'b1);
    rsp_end(10'h200, 32'h02000200, 1'b0);
    for (int i = 0; i < 200 && !flush_ack; i++) neg();
    check_eq("t5_ack_seen", 128'(flush_ack), 128'd1);
    check_eq("t5_erase_count", 128'(erase_cnt), 128'd64);
    neg();
    check_eq("t5_ack_pulse", 128'(flush_ack), 128'd0);
    for (int i = 0; i < 5; i++) neg();
    check_eq("t5_ack_count", 128'(ack_cnt), 128'd1);
    check_eq("t5_no_retrigger", 128'(erase_cnt), 128'd64);
    tick();
    issue(10'h300, 1'b0, 8'h22);
    flush_req = 1'b0;
    rsp_start(10'h300, 1'b1, 2'b00, 32'h03000300, 1'b1);
    rsp_end(10'h300, 32'h03000300, 1'b0);
    tick();

    // 6a) reset with a completion held and a fetch outstanding
    cpl_ready = 1'b0;
    issue(10'h040, 1'b0, 8'h23);
    issue(10'h080, 1'b0, 8'h20);
    rsp_start(10'h040, 1'b1, 2'b00, 32'h0F0F0F0F, 1'b1);
    rsp_end(10'h040, 32'h0F0F0F0F, 1'b0);
    tick();
    neg();
    check_eq("t6_cpl_held", 128'(cpl_valid), 128'd1);
    check_eq("t6_rready_bp", 128'(mst_rready), 128'd0);
    tick();
    arst = 1'b1;
    neg();
    check_eq("t6_rst_cpl_valid", 128'(cpl_valid), 128'd0);
    check_eq("t6_rst_cache_wen", 128'(cache_wen), 128'd0);
    tick();
    arst = 1'b0; cpl_ready = 1'b1;
    issue(10'h080, 1'b0, 8'h20);
    rsp_start(10'h080, 1'b1, 2'b00, 32'h08080808, 1'b1);
    rsp_end(10'h080, 32'h08080808, 1'b0);
    tick();

    // 6b) reset in the middle of the erase sweep
    erase_cnt = 0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    arst = 1'b1;
    neg();
    check_eq("t6_mid_erase_started", 128'(erase_cnt > 4), 128'd1);
    check_eq("t6_erase_rst_wen", 128'(cache_wen), 128'd0);
    check_eq("t6_erase_rst_ack", 128'(flush_ack), 128'd0);
    tick();
    arst = 1'b0;
    neg();
    check_eq("t6_run_no_wen", 128'(cache_wen), 128'd0);
    tick();
    issue(10'h040, 1'b0, 8'h20);
    rsp_start(10'h040, 1'b1, 2'b00, 32'h44440000, 1'b1);
    rsp_end(10'h040, 32'h44440000, 1'b0);
    tick();

    // Stray completion with nothing outstanding: consumed, no cache write
    rsp_start(10'h3F0, 1'b1, 2'b00, 32'h55555555, 1'b0);
    tick();
    mst_rvalid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
